fp_mult_gen: RTL and testbench

Parametrised, byte-serial IEEE-754-style floating-point multiplier, and the successor to the fixed 64-bit fp_mult. Operand format (exponent and fraction widths), bus width and rounding mode are configurable, and the block reports exception flags. Operands stream in over a narrow DATA_IN bus. The mantissa product is formed by an iterative shift-add datapath. The result streams out on DATA_OUT while READY is high. It sits behind the same byte-serial host port as fp_mult and is a drop-in replacement with default parameters and RM=00.

---
 rtl/fp_mult_gen.sv | 241 ++++++++++++++++++++++++
 tb/tb_fp_mult_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_gen.sv
// rtl/fp_mult_gen.sv - byte-serial parametrised IEEE-754-style multiplier with rounding modes and flags
module fp_mult_gen #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int BUS_W  = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic [BUS_W-1:0] DATA_IN,
    input  logic [1:0]       RM,
    output logic [BUS_W-1:0] DATA_OUT,
    output logic             READY,
    output logic [3:0]       FLAGS
);
    localparam int N     = 1 + EXP_W + FRAC_W;
    localparam int WORDS = N / BUS_W;
    localparam int SW    = FRAC_W + 1;
    localparam int PW    = 2 * SW;
    localparam int EW    = EXP_W + 2;
    localparam int CW    = $clog2(2 * WORDS + SW + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    localparam logic signed [EW-1:0] BIAS_E = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] EMAX_E = EW'(2 ** EXP_W - 1);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E = EW'(0);

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*N-1:0]       op_q;
    logic [1:0]           rm_q;
    logic [PW-1:0]        prod_q, prod_d;
    logic [SW-1:0]        mant_q;
    logic                 g_q, r_q, s_q;
    logic signed [EW-1:0] e_q;
    logic [N-1:0]         result_q, res_d;
    logic [BUS_W-1:0]     dout_q;
    logic                 ready_q;
    logic [3:0]           flags_q, flags_d;

    // Operand decode; exp=0 operands are flushed to zero on input
    logic               sx, sy, sgn;
    logic [EXP_W-1:0]   ex, ey;
    logic [FRAC_W-1:0]  fx, fy;
    logic               x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_snan, y_snan;
    logic [SW-1:0]      ma, mb, mb_sh;
    logic [CW-1:0]      bit_idx;
    logic signed [EW-1:0] e_raw;

    assign {sx, ex, fx} = op_q[N-1:0];
    assign {sy, ey, fy} = op_q[2*N-1:N];
    assign sgn    = sx ^ sy;
    assign x_zero = (ex == '0);
    assign y_zero = (ey == '0);
    assign x_nan  = (&ex) && (|fx);
    assign y_nan  = (&ey) && (|fy);
    assign x_inf  = (&ex) && !(|fx);
    assign y_inf  = (&ey) && !(|fy);
    assign x_snan = x_nan && !fx[FRAC_W-1];
    assign y_snan = y_nan && !fy[FRAC_W-1];
    assign ma     = x_zero ? '0 : {1'b1, fx};
    assign mb     = y_zero ? '0 : {1'b1, fy};
    assign e_raw  = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS_E;

    // Multiplier bits are consumed MSB first so the product only ever shifts left
    assign bit_idx = CW'(FRAC_W) - cnt_q;
    assign mb_sh   = mb >> bit_idx;
    assign prod_d  = {prod_q[PW-2:0], 1'b0} + (mb_sh[0] ? {{SW{1'b0}}, ma} : {PW{1'b0}});

    logic                 inexact, inc, carry;
    logic [SW:0]          sum;
    logic [FRAC_W-1:0]    frac_r;
    logic signed [EW-1:0] e_r;
    logic [N-1:0]         qnan_w, inf_w, max_w, zero_w;

    always_comb begin
        inexact = g_q | r_q | s_q;
        case (rm_q)
            2'b00:   inc = g_q & (r_q | s_q | mant_q[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = !sgn & inexact;
            default: inc = sgn & inexact;
        endcase
        sum    = {1'b0, mant_q} + {{SW{1'b0}}, inc};
        carry  = sum[SW];
        frac_r = carry ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
        e_r    = carry ? e_q + ONE_E : e_q;
        qnan_w = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
        inf_w  = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        max_w  = {sgn, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
        zero_w = {sgn, {(N-1){1'b0}}};
        res_d   = {sgn, e_r[EXP_W-1:0], frac_r};
        flags_d = {3'b000, inexact};
        if (x_nan || y_nan) begin
            res_d   = qnan_w;
            flags_d = {x_snan | y_snan, 3'b000};
        end else if ((x_inf && y_zero) || (y_inf && x_zero)) begin
            res_d   = qnan_w;
            flags_d = 4'b1000;
        end else if (x_inf || y_inf) begin
            res_d   = inf_w;
            flags_d = 4'b0000;
        end else if (x_zero || y_zero) begin
            res_d   = zero_w;
            flags_d = 4'b0000;
        end else if (e_r >= EMAX_E) begin
            flags_d = 4'b0101;
            case (rm_q)
                2'b00:   res_d = inf_w;
                2'b01:   res_d = max_w;
                2'b10:   res_d = sgn ? max_w : inf_w;
                default: res_d = sgn ? inf_w : max_w;
            endcase
        end else if (e_r <= ZERO_E) begin
            res_d   = zero_w;
            flags_d = 4'b0011;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (ENABLE) begin
                state_d = S_LOAD;
                cnt_d   = CW'(1);
            end
            S_LOAD: if (ENABLE) begin
                if (cnt_q == CW'(2 * WORDS - 1)) begin
                    state_d = S_MUL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(FRAC_W)) begin
                    state_d = S_NORM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_NORM:  state_d = S_ROUND;
            S_ROUND: begin
                state_d = S_OUT;
                cnt_d   = CW'(1);
            end
            S_OUT: begin
                if (cnt_q == CW'(WORDS)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rm_q     <= '0;
            prod_q   <= '0;
            mant_q   <= '0;
            g_q      <= 1'b0;
            r_q      <= 1'b0;
            s_q      <= 1'b0;
            e_q      <= '0;
            result_q <= '0;
            dout_q   <= '0;
            ready_q  <= 1'b0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            case (state_q)
                S_IDLE: if (ENABLE) begin
                    op_q    <= {DATA_IN, op_q[2*N-1:BUS_W]};
                    flags_q <= '0;
                end
                S_LOAD: if (ENABLE) begin
                    op_q <= {DATA_IN, op_q[2*N-1:BUS_W]};
                    if (cnt_q == CW'(2 * WORDS - 1)) begin
                        rm_q   <= RM;
                        prod_q <= '0;
                    end
                end
                S_MUL: prod_q <= prod_d;
                S_NORM: begin
                    if (prod_q[PW-1]) begin
                        mant_q <= prod_q[PW-1:SW];
                        g_q    <= prod_q[SW-1];
                        r_q    <= prod_q[SW-2];
                        s_q    <= |prod_q[SW-3:0];
                        e_q    <= e_raw + ONE_E;
                    end else begin
                        mant_q <= prod_q[PW-2:SW-1];
                        g_q    <= prod_q[SW-2];
                        r_q    <= prod_q[SW-3];
                        s_q    <= |prod_q[SW-4:0];
                        e_q    <= e_raw;
                    end
                end
                S_ROUND: begin
                    result_q <= res_d >> BUS_W;
                    dout_q   <= res_d[BUS_W-1:0];
                    ready_q  <= 1'b1;
                    flags_q  <= flags_d;
                end
                S_OUT: begin
                    if (cnt_q == CW'(WORDS)) begin
                        ready_q <= 1'b0;
                        dout_q  <= '0;
                    end else begin
                        dout_q   <= result_q[BUS_W-1:0];
                        result_q <= result_q >> BUS_W;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DATA_OUT = dout_q;
    assign READY    = ready_q;
    assign FLAGS    = flags_q;
endmodule

// File: tb/tb_fp_mult_gen.sv
// tb/tb_fp_mult_gen.sv - scoreboard bench for fp_mult_gen, double and single precision instances
module tb_fp_mult_gen;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_d, en_s;
    logic [7:0] din_d, din_s;
    logic [1:0] rm_d, rm_s;
    logic [7:0] dout_d, dout_s;
    logic       rdy_d, rdy_s;
    logic [3:0] flg_d, flg_s;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flg;
        int          t0;
    } exp_t;
    exp_t qd[$];
    exp_t qs[$];

    fp_mult_gen dut_d (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(en_d), .DATA_IN(din_d), .RM(rm_d),
        .DATA_OUT(dout_d), .READY(rdy_d), .FLAGS(flg_d)
    );

    fp_mult_gen #(.EXP_W(8), .FRAC_W(23), .BUS_W(8)) dut_s (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(en_s), .DATA_IN(din_s), .RM(rm_s),
        .DATA_OUT(dout_s), .READY(rdy_s), .FLAGS(flg_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Double-precision monitor: gathers one READY burst and scores it
    initial begin
        int          n;
        int          c;
        logic [63:0] got;
        logic [3:0]  f;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rdy_d === 1'b1) begin
                got = '0;
                got[7:0] = dout_d;
                f = flg_d;
                c = cyc;
                n = 1;
                @(negedge clk);
                while (rdy_d === 1'b1 && n < 16) begin
                    if (n < 8) got[n*8 +: 8] = dout_d;
                    n++;
                    @(negedge clk);
                end
                chk("d_dout_idle", 64'(dout_d), 64'd0);
                if (qd.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL d_unexpected: got %h, expected no result", got);
                end else begin
                    e = qd.pop_front();
                    chk("d_words", 64'(n), 64'd8);
                    chk("d_result", got, e.res);
                    chk("d_flags", 64'(f), 64'(e.flg));
                    chk("d_latency", 64'(c - e.t0), 64'd55);
                end
            end
        end
    end

    initial begin
        int          n;
        int          c;
        logic [63:0] got;
        logic [3:0]  f;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rdy_s === 1'b1) begin
                got = '0;
                got[7:0] = dout_s;
                f = flg_s;
                c = cyc;
                n = 1;
                @(negedge clk);
                while (rdy_s === 1'b1 && n < 16) begin
                    if (n < 4) got[n*8 +: 8] = dout_s;
                    n++;
                    @(negedge clk);
                end
                if (qs.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL s_unexpected: got %h, expected no result", got);
                end else begin
                    e = qs.pop_front();
                    chk("s_words", 64'(n), 64'd4);
                    chk("s_result", got, e.res);
                    chk("s_flags", 64'(f), 64'(e.flg));
                    chk("s_latency", 64'(c - e.t0), 64'd26);
                end
            end
        end
    end

    task automatic run_d(input logic [63:0] x, input logic [63:0] y, input logic [1:0] rm,
                         input logic [63:0] res, input logic [3:0] flg, input bit pause,
                         input bit abort);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (pause && i == 6) begin
                en_d = 1'b0;
                repeat (3) @(negedge clk);
            end
            en_d  = 1'b1;
            din_d = (i < 8) ? x[i*8 +: 8] : y[(i-8)*8 +: 8];
            rm_d  = rm;
        end
        @(negedge clk);
        en_d  = 1'b0;
        din_d = 8'h00;
        if (abort) begin
            repeat (10) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_ready", 64'(rdy_d), 64'd0);
            chk("rst_dout", 64'(dout_d), 64'd0);
            chk("rst_flags", 64'(flg_d), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
        end else begin
            e.res = res;
            e.flg = flg;
            e.t0  = cyc;
            qd.push_back(e);
            for (int k = 0; k < 200 && qd.size() != 0; k++) @(negedge clk);
            if (qd.size() != 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL d_timeout: got no result, expected %h", res);
                void'(qd.pop_front());
            end
            @(negedge clk);
        end
    endtask

    task automatic run_s(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm,
                         input logic [31:0] res, input logic [3:0] flg);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en_s  = 1'b1;
            din_s = (i < 4) ? x[i*8 +: 8] : y[(i-4)*8 +: 8];
            rm_s  = rm;
        end
        @(negedge clk);
        en_s  = 1'b0;
        din_s = 8'h00;
        e.res = {32'd0, res};
        e.flg = flg;
        e.t0  = cyc;
        qs.push_back(e);
        for (int k = 0; k < 200 && qs.size() != 0; k++) @(negedge clk);
        if (qs.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL s_timeout: got no result, expected %h", res);
            void'(qs.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en_d = 1'b0; din_d = 8'h00; rm_d = 2'b00;
        en_s = 1'b0; din_s = 8'h00; rm_s = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready_d", 64'(rdy_d), 64'd0);
        chk("reset_dout_d", 64'(dout_d), 64'd0);
        chk("reset_flags_d", 64'(flg_d), 64'd0);
        chk("reset_ready_s", 64'(rdy_s), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_d(64'h3FF8000000000000, 64'h4000000000000000, 2'b00, 64'h4008000000000000, 4'b0000, 0, 0);
        run_d(64'h7FF0000000000000, 64'h0000000000000000, 2'b00, 64'h7FF8000000000000, 4'b1000, 0, 0);
        run_d(64'h7FF0000000000001, 64'h3FF0000000000000, 2'b00, 64'h7FF8000000000000, 4'b1000, 0, 0);
        run_d(64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 2'b00, 64'h7FF0000000000000, 4'b0101, 0, 0);
        run_d(64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 2'b01, 64'h7FEFFFFFFFFFFFFF, 4'b0101, 0, 0);
        run_d(64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 2'b11, 64'hFFF0000000000000, 4'b0101, 0, 0);
        run_d(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b00, 64'h3FF0000000000002, 4'b0001, 0, 0);
        run_d(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b10, 64'h3FF0000000000003, 4'b0001, 0, 0);
        run_d(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b01, 64'h3FF0000000000002, 4'b0001, 0, 0);
        run_d(64'h0010000000000000, 64'h3FE0000000000000, 2'b00, 64'h0000000000000000, 4'b0011, 0, 0);
        run_d(64'h0010000000000000, 64'hBFE0000000000000, 2'b00, 64'h8000000000000000, 4'b0011, 0, 0);
        run_d(64'h000FFFFFFFFFFFFF, 64'h4000000000000000, 2'b00, 64'h0000000000000000, 4'b0000, 0, 0);
        run_d(64'h3FF8000000000000, 64'h4000000000000000, 2'b00, 64'h4008000000000000, 4'b0000, 1, 0);
        run_d(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b10, 64'h0, 4'b0000, 0, 1);
        run_d(64'h3FF8000000000000, 64'h4000000000000000, 2'b01, 64'h4008000000000000, 4'b0000, 0, 0);
        run_s(32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
